// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT FIFO between the UART receiver and its consumer.
// Occupancy comes from a registered count; the flags are decodes of that count.
module uart_rx_fifo #(
    parameter int unsigned DataWidth       = 8,
    parameter int unsigned Depth           = 16,
    parameter int unsigned AlmostFullLevel = 12,
    localparam int unsigned PtrW           = $clog2(Depth),
    localparam int unsigned CntW           = PtrW + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 wr_en_i,
    input  logic [DataWidth-1:0] wr_data_i,
    input  logic                 rd_en_i,
    output logic [DataWidth-1:0] rd_data_o,
    output logic                 empty_o,
    output logic                 full_o,
    output logic                 almost_full_o,
    output logic [CntW-1:0]      count_o,
    output logic                 overrun_o,
    input  logic                 flush_i,
    input  logic                 clr_overrun_i
);

    logic [DataWidth-1:0] mem_q [Depth];
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]      count_q, count_d;
    logic                 overrun_q, overrun_d;
    logic                 push, pop, drop;

    always_comb begin
        pop       = rd_en_i && (count_q != '0);
        // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
        push      = wr_en_i && ((count_q != CntW'(Depth)) || pop);
        drop      = wr_en_i && !push;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;

        if (drop) begin
            overrun_d = 1'b1;
        end else if (clr_overrun_i) begin
            overrun_d = 1'b0;
        end

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    // Storage is deliberately left unreset; rd_data_o is meaningless while empty.
    always_ff @(posedge clk_i) begin
        if (push && !flush_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o     = mem_q[rd_ptr_q];
    assign count_o       = count_q;
    assign empty_o       = (count_q == '0);
    assign full_o        = (count_q == CntW'(Depth));
    assign almost_full_o = (count_q >= CntW'(AlmostFullLevel));
    assign overrun_o     = overrun_q;

endmodule
